// File: rtl/aes_pkg.sv
// aes_pkg: shared AES key-schedule constants, state enum, S-box and xtime helpers.
// Contents:
//   NR, KEY_W   - round count (10) and key width (128), AES-128 only
//   RCON_INIT   - first round constant
//   ks_state_t  - key-schedule controller states IDLE / EXPAND / READY
//   sbox(b)     - forward AES S-box lookup
//   xtime(b)    - GF(2^8) multiply by x, used to advance rcon
package aes_pkg;
    localparam int NR = 10;
    localparam int KEY_W = 128;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {IDLE, EXPAND, READY} ks_state_t;

    // Entry 0 sits in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
endpackage

// File: rtl/aes_key_round.sv
// aes_key_round: one combinational AES-128 key-schedule step.
// Ports:
//   prev_key [127:0] in  - previous round key, words w0..w3 MSB first
//   rcon     [7:0]   in  - round constant for this step
//   next_key [127:0] out - next round key
module aes_key_round
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0] prev_key,
    input  logic [7:0]       rcon,
    output logic [KEY_W-1:0] next_key
);
    logic [31:0] w3, t, n0, n1, n2, n3;

    assign w3 = prev_key[31:0];
    // SubWord(RotWord(w3)): rotate left by one byte, then substitute each byte
    assign t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h0};
    assign n0 = prev_key[127:96] ^ t;
    assign n1 = prev_key[95:64] ^ n0;
    assign n2 = prev_key[63:32] ^ n1;
    assign n3 = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};
endmodule

// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl: sequential AES-128 key expansion into an 11-slot round-key file with a 1-cycle read port.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   zeroize             - clears all slots and aborts (only with KEYSCHED_ZEROIZE_EN defined)
//   keyValid/keyReady   - cipher key handshake, cipherKey sampled on keyValid && keyReady
//   busy                - expansion in progress
//   keysReady           - all 11 round keys valid
//   rdEn, rdIdx         - read request for round key 0..10
//   rdValid/rdKey/rdErr - registered read response one cycle after rdEn
// Optional feature macro: KEYSCHED_ZEROIZE_EN.
module key_schedule_ctrl
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
`ifdef KEYSCHED_ZEROIZE_EN
    input  logic             zeroize,
`endif
    input  logic             keyValid,
    output logic             keyReady,
    input  logic [KEY_W-1:0] cipherKey,
    output logic             busy,
    output logic             keysReady,
    input  logic             rdEn,
    input  logic [3:0]       rdIdx,
    output logic             rdValid,
    output logic [KEY_W-1:0] rdKey,
    output logic             rdErr
);
    ks_state_t        state;
    logic [3:0]       round;
    logic [7:0]       rcon;
    logic [KEY_W-1:0] slots [0:NR];
    logic [KEY_W-1:0] next_key;
    logic             zero_req;
    logic             rd_ok;

`ifdef KEYSCHED_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    aes_key_round u_round (
        .prev_key(slots[round - 4'd1]),
        .rcon    (rcon),
        .next_key(next_key)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            round     <= '0;
            rcon      <= RCON_INIT;
            keyReady  <= 1'b1;
            busy      <= 1'b0;
            keysReady <= 1'b0;
        end else if (zero_req) begin
            // Zeroize wins over a simultaneous key handshake.
            state     <= IDLE;
            round     <= '0;
            rcon      <= RCON_INIT;
            keyReady  <= 1'b1;
            busy      <= 1'b0;
            keysReady <= 1'b0;
            for (int i = 0; i <= NR; i++) slots[i] <= '0;
        end else begin
            case (state)
                IDLE, READY: begin
                    if (keyValid) begin
                        slots[0]  <= cipherKey;
                        round     <= 4'd1;
                        rcon      <= RCON_INIT;
                        state     <= EXPAND;
                        keyReady  <= 1'b0;
                        busy      <= 1'b1;
                        keysReady <= 1'b0;
                    end
                end
                EXPAND: begin
                    slots[round] <= next_key;
                    rcon         <= xtime(rcon);
                    round        <= round + 4'd1;
                    if (round == 4'(NR)) begin
                        state     <= READY;
                        busy      <= 1'b0;
                        keyReady  <= 1'b1;
                        keysReady <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reads see the pre-edge keysReady, so a read alongside a reload still gets the old key.
    assign rd_ok = keysReady && (rdIdx <= 4'(NR)) && !zero_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdValid <= 1'b0;
            rdErr   <= 1'b0;
            rdKey   <= '0;
        end else begin
            rdValid <= rdEn;
            rdErr   <= rdEn && !rd_ok;
            rdKey   <= (rdEn && rd_ok) ? slots[rdIdx] : '0;
        end
    end
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb_key_schedule_ctrl: directed, table-driven self-checking bench for key_schedule_ctrl.
module tb_key_schedule_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic         keyValid;
    logic         keyReady;
    logic [127:0] cipherKey;
    logic         busy;
    logic         keysReady;
    logic         rdEn;
    logic [3:0]   rdIdx;
    logic         rdValid;
    logic [127:0] rdKey;
    logic         rdErr;
`ifdef KEYSCHED_ZEROIZE_EN
    logic         zeroize;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic         rd_en;
        logic [3:0]   idx;
        logic         exp_valid;
        logic         exp_err;
        logic [127:0] exp_key;
    } rd_vec_t;

    rd_vec_t      vecs [14];
    logic [127:0] fips [0:10];
    logic [127:0] key_a;

    key_schedule_ctrl dut (
        .clk      (clk),
        .rst      (rst),
`ifdef KEYSCHED_ZEROIZE_EN
        .zeroize  (zeroize),
`endif
        .keyValid (keyValid),
        .keyReady (keyReady),
        .cipherKey(cipherKey),
        .busy     (busy),
        .keysReady(keysReady),
        .rdEn     (rdEn),
        .rdIdx    (rdIdx),
        .rdValid  (rdValid),
        .rdKey    (rdKey),
        .rdErr    (rdErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_keyReady"}, 128'(keyReady), 128'd1);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_keysReady"}, 128'(keysReady), 128'd0);
        chk({tag, "_rdValid"}, 128'(rdValid), 128'd0);
        chk({tag, "_rdErr"}, 128'(rdErr), 128'd0);
        chk({tag, "_rdKey"}, rdKey, 128'd0);
    endtask

    task automatic load(input logic [127:0] k);
        keyValid  = 1'b1;
        cipherKey = k;
        tick();
        keyValid  = 1'b0;
    endtask

    task automatic do_read(input string name, input logic [3:0] idx, input logic exp_err, input logic [127:0] exp_key);
        rdEn  = 1'b1;
        rdIdx = idx;
        tick();
        rdEn  = 1'b0;
        chk({name, "_valid"}, 128'(rdValid), 128'd1);
        chk({name, "_err"}, 128'(rdErr), 128'(exp_err));
        chk({name, "_key"}, rdKey, exp_key);
    endtask

    initial begin
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        key_a    = fips[0];
        for (int i = 0; i <= 10; i++) vecs[i] = '{1'b1, 4'(i), 1'b1, 1'b0, fips[i]};
        vecs[11] = '{1'b1, 4'd11, 1'b1, 1'b1, 128'd0};
        vecs[12] = '{1'b1, 4'd15, 1'b1, 1'b1, 128'd0};
        vecs[13] = '{1'b0, 4'd3, 1'b0, 1'b0, 128'd0};

        rst = 1'b1; keyValid = 1'b0; cipherKey = '0; rdEn = 1'b0; rdIdx = '0;
`ifdef KEYSCHED_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        tick(); tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        // FIPS-197 load, reading every cycle while expanding
        load(key_a);
        chk("hs_busy", 128'(busy), 128'd1);
        chk("hs_keyReady", 128'(keyReady), 128'd0);
        rdEn = 1'b1; rdIdx = 4'd1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            chk($sformatf("exp%0d_rdValid", n), 128'(rdValid), 128'd1);
            chk($sformatf("exp%0d_rdErr", n), 128'(rdErr), 128'd1);
            chk($sformatf("exp%0d_rdKey", n), rdKey, 128'd0);
            chk($sformatf("exp%0d_busy", n), 128'(busy), 128'(n < 10));
            chk($sformatf("exp%0d_keysReady", n), 128'(keysReady), 128'(n == 10));
        end
        rdEn = 1'b0;
        chk("ready_keyReady", 128'(keyReady), 128'd1);

        // Back-to-back table reads, then out-of-range and idle entries
        for (int i = 0; i < 14; i++) begin
            rdEn  = vecs[i].rd_en;
            rdIdx = vecs[i].idx;
            tick();
            chk($sformatf("vec%0d_valid", i), 128'(rdValid), 128'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_err", i), 128'(rdErr), 128'(vecs[i].exp_err));
            chk($sformatf("vec%0d_key", i), rdKey, vecs[i].exp_key);
        end
        rdEn = 1'b0;

        // Reload zero key from READY while reading idx 10
        rdEn = 1'b1; rdIdx = 4'd10;
        load(128'd0);
        rdEn = 1'b0;
        chk("reload_rdErr", 128'(rdErr), 128'd0);
        chk("reload_rdKey", rdKey, fips[10]);
        chk("reload_keysReady", 128'(keysReady), 128'd0);
        do_read("reload_stale", 4'd10, 1'b1, 128'd0);
        repeat (9) tick();
        chk("reload_done", 128'(keysReady), 128'd1);
        do_read("zero_r10", 4'd10, 1'b0, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        do_read("zero_r0", 4'd0, 1'b0, 128'd0);

        // Reset mid-expansion, then a clean reload
        load(key_a);
        repeat (4) tick();
        chk("mid_busy", 128'(busy), 128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midrst");
        repeat (3) tick();
        chk("midrst_idle_busy", 128'(busy), 128'd0);
        load(key_a);
        repeat (10) tick();
        chk("after_rst_ready", 128'(keysReady), 128'd1);
        do_read("after_rst_r10", 4'd10, 1'b0, fips[10]);
        do_read("after_rst_r4", 4'd4, 1'b0, fips[4]);

`ifdef KEYSCHED_ZEROIZE_EN
        keyValid = 1'b1; cipherKey = 128'h0123456789abcdef0123456789abcdef;
        rdEn = 1'b1; rdIdx = 4'd3; zeroize = 1'b1;
        tick();
        keyValid = 1'b0; rdEn = 1'b0; zeroize = 1'b0;
        chk("zer_rdErr", 128'(rdErr), 128'd1);
        chk("zer_rdKey", rdKey, 128'd0);
        chk("zer_keysReady", 128'(keysReady), 128'd0);
        chk("zer_busy", 128'(busy), 128'd0);
        chk("zer_keyReady", 128'(keyReady), 128'd1);
        chk("zer_state", 128'(dut.state), 128'(aes_pkg::IDLE));
        for (int i = 0; i <= 10; i++) chk($sformatf("zer_slot%0d", i), dut.slots[i], 128'd0);
        tick();
        chk("zer_still_idle", 128'(busy), 128'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
